video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Programmable raster timing generator; sits directly upstream of the test-pattern/overlay stage.
- Drives that stage's x, y, hn, vn and dn inputs.
- Produces pixel/line counters, sync strobes with programmable polarity, data-enable, and frame/line start pulses.
- Timing inputs are shadowed and only take effect at frame boundaries, so mode changes never produce torn frames.

Parameters:
X_BITS, 13, width of horizontal counters and horizontal timing inputs
Y_BITS, 13, width of vertical counters and vertical timing inputs

Ports:
clk_in  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
ce_pix  in  1  pixel clock enable; all state holds when low
h_total  in  X_BITS  total pixels per line
h_active  in  X_BITS  active pixels per line
h_fp  in  X_BITS  horizontal front porch, pixels
h_sync  in  X_BITS  hsync width, pixels
v_total  in  Y_BITS  total lines per frame
v_active  in  Y_BITS  active lines per frame
v_fp  in  Y_BITS  vertical front porch, lines
v_sync  in  Y_BITS  vsync width, lines
hs_pol  in  1  asserted level of hn_out
vs_pol  in  1  asserted level of vn_out
x  out  X_BITS  horizontal position, 0..h_total-1
y  out  Y_BITS  vertical position, 0..v_total-1
hn_out  out  1  horizontal sync
vn_out  out  1  vertical sync
dn_out  out  1  data enable (active area)
line_start  out  1  one-cycle pulse with x==0
frame_start  out  1  one-cycle pulse with x==0 and y==0

Behaviour:
- Reset (async, active-high):
  - hc=0, vc=0, all shadow timing regs=0, load_pend=1.
  - Outputs: x=0, y=0, dn_out=0, line_start=0, frame_start=0.
  - hn_out=0 and vn_out=0 during reset.
  - Reset mid-frame aborts the frame immediately; the restart sequence below follows.
- Nothing changes on any edge with ce_pix=0, including the load step.
- Load step: first ce_pix edge after reset release with load_pend=1:
  - Shadows capture all eight timing inputs plus hs_pol and vs_pol.
  - load_pend clears; counters stay 0; outputs keep their reset values.
- Counting, every subsequent ce_pix edge:
  - Outputs are registered from the current hc/vc: one cycle latency, with x, y, hn, vn, dn and the pulses all mutually aligned.
  - x=hc, y=vc.
  - dn_out = (hc < h_active_s) && (vc < v_active_s).
  - hsync region: h_active_s+h_fp_s <= hc < h_active_s+h_fp_s+h_sync_s.
  - hn_out = hs_pol_s when in the hsync region, else ~hs_pol_s.
  - vsync region: v_active_s+v_fp_s <= vc < v_active_s+v_fp_s+v_sync_s, evaluated on vc only, so vn_out changes with line_start.
  - vn_out = vs_pol_s when in the vsync region, else ~vs_pol_s.
  - line_start = (hc==0); frame_start = (hc==0 && vc==0).
- Counter update:
  - Line wrap when hc+1 >= h_total_s, computed at X_BITS+1 width: hc<=0, and vc advances.
  - Frame wrap when vc+1 >= v_total_s, computed at Y_BITS+1 width: vc<=0.
  - Otherwise hc<=hc+1.
  - h_total_s of 0 or 1 means a wrap every cycle (x constant 0); same rule applies to v_total_s.
- Shadow reload: on the edge where hc wraps and vc wraps (last pixel of the frame), shadows recapture all inputs.
  - New values apply from the next frame's first pixel.
  - Input changes at any other time have no effect until then.
- Region sums are computed at width+1 with no saturation. Inconsistent programming is not corrected:
  - sync extending past total gives a truncated sync;
  - active > total gives dn high across the whole line.

Test Plan:
- Timing h_total=10, h_active=6, h_fp=1, h_sync=2, v_total=5, v_active=3, v_fp=1, v_sync=1, both pols=1, ce_pix=1, release reset:
  - first output edge after the load step gives x=0, y=0, frame_start=1, dn_out=1;
  - dn_out high for x 0..5 on y 0..2;
  - hn_out high only at x 7,8;
  - vn_out high for all of y=4;
  - frame period 50 cycles.
- Same timing with hs_pol=0, vs_pol=0 -> hn_out low only at x 7,8; vn_out low only on y=4; idle level high.
- Change h_active to 4 mid-frame (y=1) -> current frame unchanged (dn through x=5); the frame after the next frame_start shows dn for x 0..3 only.
- Toggle ce_pix 1-of-3 -> outputs step only on enabled edges; the sequence is identical to scenario 1.
- Assert reset at x=3, y=2 -> all outputs 0 immediately (asynchronous); after release, one load edge, then frame_start with x=0, y=0.
- h_total=1, v_total=1 -> x=0 and y=0 constantly; line_start=1 and frame_start=1 on every ce edge.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing generator with frame-boundary
// shadowing of all timing inputs and registered, mutually aligned outputs.
module video_timing_gen #(
    parameter int X_BITS = 13,
    parameter int Y_BITS = 13
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic [X_BITS-1:0] h_total,
    input  logic [X_BITS-1:0] h_active,
    input  logic [X_BITS-1:0] h_fp,
    input  logic [X_BITS-1:0] h_sync,
    input  logic [Y_BITS-1:0] v_total,
    input  logic [Y_BITS-1:0] v_active,
    input  logic [Y_BITS-1:0] v_fp,
    input  logic [Y_BITS-1:0] v_sync,
    input  logic              hs_pol,
    input  logic              vs_pol,
    output logic [X_BITS-1:0] x,
    output logic [Y_BITS-1:0] y,
    output logic              hn_out,
    output logic              vn_out,
    output logic              dn_out,
    output logic              line_start,
    output logic              frame_start
);
    localparam int SW = 4 * X_BITS + 4 * Y_BITS + 2;

    logic [SW-1:0]     shd_q, shd_d, shd_in;
    logic [X_BITS-1:0] h_total_s, h_active_s, h_fp_s, h_sync_s;
    logic [Y_BITS-1:0] v_total_s, v_active_s, v_fp_s, v_sync_s;
    logic              hs_pol_s, vs_pol_s;
    logic [X_BITS-1:0] hc_q, hc_d, x_q, x_d;
    logic [Y_BITS-1:0] vc_q, vc_d, y_q, y_d;
    logic              load_pend_q, load_pend_d;
    logic              hn_q, hn_d, vn_q, vn_d, dn_q, dn_d, ls_q, ls_d, fs_q, fs_d;
    logic [X_BITS:0]   hc_nx, h_sync_beg, h_sync_end;
    logic [Y_BITS:0]   vc_nx, v_sync_beg, v_sync_end;
    logic              h_wrap, v_wrap, in_hs, in_vs;

    // All timing inputs travel as one shadow word so reload is a single capture.
    assign shd_in = {h_total, h_active, h_fp, h_sync, v_total, v_active, v_fp, v_sync, hs_pol, vs_pol};
    assign {h_total_s, h_active_s, h_fp_s, h_sync_s,
            v_total_s, v_active_s, v_fp_s, v_sync_s, hs_pol_s, vs_pol_s} = shd_q;

    assign hc_nx      = {1'b0, hc_q} + {{X_BITS{1'b0}}, 1'b1};
    assign vc_nx      = {1'b0, vc_q} + {{Y_BITS{1'b0}}, 1'b1};
    assign h_wrap     = hc_nx >= {1'b0, h_total_s};
    assign v_wrap     = vc_nx >= {1'b0, v_total_s};
    assign h_sync_beg = {1'b0, h_active_s} + {1'b0, h_fp_s};
    assign h_sync_end = h_sync_beg + {1'b0, h_sync_s};
    assign v_sync_beg = {1'b0, v_active_s} + {1'b0, v_fp_s};
    assign v_sync_end = v_sync_beg + {1'b0, v_sync_s};
    assign in_hs      = ({1'b0, hc_q} >= h_sync_beg) && ({1'b0, hc_q} < h_sync_end);
    assign in_vs      = ({1'b0, vc_q} >= v_sync_beg) && ({1'b0, vc_q} < v_sync_end);

    always_comb begin
        hc_d        = hc_q;
        vc_d        = vc_q;
        shd_d       = shd_q;
        load_pend_d = load_pend_q;
        x_d         = x_q;
        y_d         = y_q;
        hn_d        = hn_q;
        vn_d        = vn_q;
        dn_d        = dn_q;
        ls_d        = ls_q;
        fs_d        = fs_q;
        if (ce_pix && load_pend_q) begin
            shd_d       = shd_in;
            load_pend_d = 1'b0;
        end else if (ce_pix) begin
            x_d   = hc_q;
            y_d   = vc_q;
            dn_d  = (hc_q < h_active_s) && (vc_q < v_active_s);
            hn_d  = in_hs ? hs_pol_s : ~hs_pol_s;
            vn_d  = in_vs ? vs_pol_s : ~vs_pol_s;
            ls_d  = hc_q == '0;
            fs_d  = (hc_q == '0) && (vc_q == '0);
            hc_d  = h_wrap ? '0 : hc_nx[X_BITS-1:0];
            vc_d  = !h_wrap ? vc_q : v_wrap ? '0 : vc_nx[Y_BITS-1:0];
            shd_d = (h_wrap && v_wrap) ? shd_in : shd_q;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            hc_q        <= '0;
            vc_q        <= '0;
            shd_q       <= '0;
            load_pend_q <= 1'b1;
            x_q         <= '0;
            y_q         <= '0;
            hn_q        <= 1'b0;
            vn_q        <= 1'b0;
            dn_q        <= 1'b0;
            ls_q        <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            shd_q       <= shd_d;
            load_pend_q <= load_pend_d;
            x_q         <= x_d;
            y_q         <= y_d;
            hn_q        <= hn_d;
            vn_q        <= vn_d;
            dn_q        <= dn_d;
            ls_q        <= ls_d;
            fs_q        <= fs_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hn_out      = hn_q;
    assign vn_out      = vn_q;
    assign dn_out      = dn_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed scenarios plus randomized timing, enable and
// reset traffic, checked against a raster-position reference model.
module tb_video_timing_gen;
    localparam int XB = 13;
    localparam int YB = 13;

    logic          clk_in = 1'b0, reset = 1'b1, ce_pix = 1'b0;
    logic [XB-1:0] h_total, h_active, h_fp, h_sync;
    logic [YB-1:0] v_total, v_active, v_fp, v_sync;
    logic          hs_pol, vs_pol;
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic          hn_out, vn_out, dn_out, line_start, frame_start;

    video_timing_gen #(.X_BITS(XB), .Y_BITS(YB)) dut (
        .clk_in(clk_in), .reset(reset), .ce_pix(ce_pix),
        .h_total(h_total), .h_active(h_active), .h_fp(h_fp), .h_sync(h_sync),
        .v_total(v_total), .v_active(v_active), .v_fp(v_fp), .v_sync(v_sync),
        .hs_pol(hs_pol), .vs_pol(vs_pol),
        .x(x), .y(y), .hn_out(hn_out), .vn_out(vn_out), .dn_out(dn_out),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0, errors = 0;
    int px, py, pend;
    int ht, ha, hf, hsw, vt, va, vf, vsw;
    bit hp, vp;
    int e_x, e_y;
    bit e_hn, e_vn, e_dn, e_ls, e_fs;
    int steps = 0, last_fs = -1, period = 0;

    wire [30:0] dut_out = {x, y, hn_out, vn_out, dn_out, line_start, frame_start};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [30:0] m_out();
        return {XB'(e_x), YB'(e_y), e_hn, e_vn, e_dn, e_ls, e_fs};
    endfunction

    function automatic void capture();
        ht = int'(h_total); ha = int'(h_active); hf = int'(h_fp); hsw = int'(h_sync);
        vt = int'(v_total); va = int'(v_active); vf = int'(v_fp); vsw = int'(v_sync);
        hp = hs_pol; vp = vs_pol;
    endfunction

    function automatic void m_reset();
        px = 0; py = 0; pend = 1;
        ht = 0; ha = 0; hf = 0; hsw = 0; vt = 0; va = 0; vf = 0; vsw = 0; hp = 0; vp = 0;
        e_x = 0; e_y = 0; e_hn = 0; e_vn = 0; e_dn = 0; e_ls = 0; e_fs = 0;
    endfunction

    // One enabled pixel: report the current raster position, then advance it.
    function automatic void m_edge();
        if (!ce_pix) return;
        if (pend != 0) begin
            capture();
            pend = 0;
            return;
        end
        e_x  = px;
        e_y  = py;
        e_dn = (px < ha) && (py < va);
        e_hn = (px >= ha + hf && px < ha + hf + hsw) ? hp : !hp;
        e_vn = (py >= va + vf && py < va + vf + vsw) ? vp : !vp;
        e_ls = px == 0;
        e_fs = px == 0 && py == 0;
        if (px + 1 >= ht) begin
            px = 0;
            if (py + 1 >= vt) begin
                py = 0;
                capture();
            end else py++;
        end else px++;
    endfunction

    task automatic step(input string tag);
        @(posedge clk_in);
        if (reset) m_reset(); else m_edge();
        #1;
        steps++;
        chk(tag, dut_out, m_out());
        if (frame_start) begin
            if (last_fs >= 0 && period == 0) period = steps - last_fs;
            last_fs = steps;
        end
    endtask

    task automatic set_cfg(input int a, b, c, d, e, f, g, h, input bit p, q);
        h_total = XB'(a); h_active = XB'(b); h_fp = XB'(c); h_sync = XB'(d);
        v_total = YB'(e); v_active = YB'(f); v_fp = YB'(g); v_sync = YB'(h);
        hs_pol = p; vs_pol = q;
    endtask

    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1 m_reset();
        chk({tag, "_async"}, dut_out, 31'd0);
        step({tag, "_held"});
        reset = 1'b0;
    endtask

    task automatic rand_cfg();
        int a, e;
        a = $urandom_range(0, 16);
        e = $urandom_range(0, 7);
        set_cfg(a, $urandom_range(0, a + 2), $urandom_range(0, 3), $urandom_range(0, 3),
                e, $urandom_range(0, e + 1), $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        int n;
        m_reset();
        set_cfg(10, 6, 1, 2, 5, 3, 1, 1, 1'b1, 1'b1);
        #1 chk("reset_state", dut_out, 31'd0);
        ce_pix = 1'b1;
        step("rst0");
        step("rst1");
        reset = 1'b0;
        step("load");
        step("first");
        chk("first_frame_start", {x, y, frame_start, dn_out}, {XB'(0), YB'(0), 2'b11});
        last_fs = steps;
        period = 0;
        for (int i = 0; i < 120; i++) step("s1_pos");
        chk("frame_period", period, 50);

        set_cfg(10, 6, 1, 2, 5, 3, 1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 150; i++) step("s2_neg");

        set_cfg(10, 6, 1, 2, 5, 3, 1, 1, 1'b1, 1'b1);
        n = 0;
        while (!(e_y == 1 && e_x == 0) && n < 200) begin step("s3_seek"); n++; end
        if (n >= 200) chk("s3_seek_timeout", 0, 1);
        h_active = XB'(4);
        for (int i = 0; i < 160; i++) step("s3_hact");

        h_active = XB'(6);
        for (int i = 0; i < 300; i++) begin
            ce_pix = (i % 3) == 0;
            step("s4_ce");
        end
        ce_pix = 1'b1;

        n = 0;
        while (!(e_x == 3 && e_y == 2) && n < 200) begin step("s5_seek"); n++; end
        if (n >= 200) chk("s5_seek_timeout", 0, 1);
        do_reset("s5_rst");
        step("s5_load");
        step("s5_first");
        chk("s5_frame_start", {x, y, frame_start}, {XB'(0), YB'(0), 1'b1});

        set_cfg(1, 1, 0, 0, 1, 1, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 80; i++) step("s6_wait");
        for (int i = 0; i < 10; i++) begin
            step("s6_tiny");
            chk("s6_pulses", {x, y, line_start, frame_start}, {XB'(0), YB'(0), 2'b11});
        end

        for (int i = 0; i < 3000; i++) begin
            ce_pix = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 39) == 0) rand_cfg();
            if ($urandom_range(0, 499) == 0) do_reset("rnd_rst");
            else step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
